riscv_alu_exec: RTL and testbench

//  RV32I execute-stage ALU: decodes aluOp/funct7/funct3 into an internal operation select,

---
 rtl/riscv_alu_exec_if.sv | 28 ++
 rtl/riscv_alu_exec.sv | 162 ++++++++++++++++
 tb/tb_riscv_alu_exec.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_alu_exec_if.sv
// Operand/control and result bundle of the RV32I execute-stage ALU.
// The master drives the operands and controls; the slave (the ALU) returns the registered results.
interface riscv_alu_exec_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic [1:0]            aluOp;
  logic [6:0]            funct7;
  logic [2:0]            funct3;
  logic [DATA_WIDTH-1:0] bus_a;
  logic [DATA_WIDTH-1:0] bus_b;
  logic [DATA_WIDTH-1:0] out;
  logic                  overflow;
  logic                  Z;
  logic                  error;
  logic [3:0]            opSel;
  logic                  out_valid;

  modport master (
    output in_valid, aluOp, funct7, funct3, bus_a, bus_b,
    input  out, overflow, Z, error, opSel, out_valid
  );

  modport slave (
    input  in_valid, aluOp, funct7, funct3, bus_a, bus_b,
    output out, overflow, Z, error, opSel, out_valid
  );
endinterface

// File: rtl/riscv_alu_exec.sv
// RV32I execute-stage ALU: decodes aluOp/funct7/funct3 and registers result and flags (1-cycle latency).
// Optional feature macro ALU_MUL_EN enables R-type MUL (funct7=0x01, funct3=000).
module riscv_alu_exec #(
  parameter int DATA_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  riscv_alu_exec_if.slave   alu
);
  localparam int SHW = $clog2(DATA_WIDTH);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SLT  = 4'd3,
    OP_SLTU = 4'd4,
    OP_XOR  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_OR   = 4'd8,
    OP_AND  = 4'd9,
    OP_MUL  = 4'd10,
    OP_NOP  = 4'd15
  } op_e;

  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

  logic signed [DATA_WIDTH-1:0] a_s, b_s, sum_s, diff_s, res_s;
  logic [SHW-1:0]               shamt;
  op_e                          op;
  logic                         err, ovf, zero;

  assign a_s    = $signed(alu.bus_a);
  assign b_s    = $signed(alu.bus_b);
  assign shamt  = alu.bus_b[SHW-1:0];
  assign sum_s  = a_s + b_s;
  assign diff_s = a_s - b_s;

  // Decode: any funct7/funct3 pair not listed becomes NOP with error raised
  always_comb begin
    op  = OP_NOP;
    err = 1'b0;
    case (alu.aluOp)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b10: begin
        case (alu.funct7)
          7'h00: begin
            case (alu.funct3)
              3'b000:  op = OP_ADD;
              3'b001:  op = OP_SLL;
              3'b010:  op = OP_SLT;
              3'b011:  op = OP_SLTU;
              3'b100:  op = OP_XOR;
              3'b101:  op = OP_SRL;
              3'b110:  op = OP_OR;
              default: op = OP_AND;
            endcase
          end
          7'h20: begin
            if (alu.funct3 == 3'b000)      op  = OP_SUB;
            else if (alu.funct3 == 3'b101) op  = OP_SRA;
            else                           err = 1'b1;
          end
`ifdef ALU_MUL_EN
          7'h01: begin
            if (alu.funct3 == 3'b000) op  = OP_MUL;
            else                      err = 1'b1;
          end
`endif
          default: err = 1'b1;
        endcase
      end
      default: begin
        case (alu.funct3)
          3'b000: op = OP_ADD;
          3'b010: op = OP_SLT;
          3'b011: op = OP_SLTU;
          3'b100: op = OP_XOR;
          3'b110: op = OP_OR;
          3'b111: op = OP_AND;
          3'b001: begin
            if (alu.funct7 == 7'h00) op  = OP_SLL;
            else                     err = 1'b1;
          end
          default: begin
            if (alu.funct7 == 7'h00)      op  = OP_SRL;
            else if (alu.funct7 == 7'h20) op  = OP_SRA;
            else                          err = 1'b1;
          end
        endcase
      end
    endcase
  end

  always_comb begin
    res_s = '0;
    ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        res_s = sum_s;
        ovf   = add_ovf(a_s[DATA_WIDTH-1], b_s[DATA_WIDTH-1], sum_s[DATA_WIDTH-1]);
      end
      OP_SUB: begin
        res_s = diff_s;
        ovf   = sub_ovf(a_s[DATA_WIDTH-1], b_s[DATA_WIDTH-1], diff_s[DATA_WIDTH-1]);
      end
      OP_SLL:  res_s = $signed(alu.bus_a << shamt);
      OP_SLT:  res_s = $signed({{(DATA_WIDTH-1){1'b0}}, (a_s < b_s)});
      OP_SLTU: res_s = $signed({{(DATA_WIDTH-1){1'b0}}, (alu.bus_a < alu.bus_b)});
      OP_XOR:  res_s = a_s ^ b_s;
      OP_SRL:  res_s = $signed(alu.bus_a >> shamt);
      OP_SRA:  res_s = a_s >>> shamt;
      OP_OR:   res_s = a_s | b_s;
      OP_AND:  res_s = a_s & b_s;
`ifdef ALU_MUL_EN
      OP_MUL:  res_s = a_s * b_s;
`endif
      default: res_s = '0;
    endcase
  end

  // NOP never reports zero even though its result is forced to 0
  assign zero = (op != OP_NOP) && (res_s == '0);

  logic signed [DATA_WIDTH-1:0] out_p1;
  logic                         ovf_p1, z_p1, err_p1, vld_p1;
  op_e                          op_p1;

  // Stage p1: result/flag register, free-running, async reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_p1 <= '0;
      ovf_p1 <= 1'b0;
      z_p1   <= 1'b0;
      err_p1 <= 1'b0;
      op_p1  <= OP_NOP;
      vld_p1 <= 1'b0;
    end else begin
      out_p1 <= res_s;
      ovf_p1 <= ovf;
      z_p1   <= zero;
      err_p1 <= err;
      op_p1  <= op;
      vld_p1 <= alu.in_valid;
    end
  end

  assign alu.out       = out_p1;
  assign alu.overflow  = ovf_p1;
  assign alu.Z         = z_p1;
  assign alu.error     = err_p1;
  assign alu.opSel     = op_p1;
  assign alu.out_valid = vld_p1;
endmodule

// File: tb/tb_riscv_alu_exec.sv
// Scoreboard bench for riscv_alu_exec: directed vectors push expected results, a monitor pops and compares.
module tb_riscv_alu_exec;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  riscv_alu_exec_if #(.DATA_WIDTH(32)) ifc ();

  riscv_alu_exec #(.DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .alu (ifc.slave)
  );

  typedef struct {
    string       name;
    logic [31:0] out;
    logic        ovf;
    logic        z;
    logic        err;
    logic [3:0]  op;
  } exp_t;

  exp_t sb[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic issue(input string name, input logic [1:0] aop, input logic [6:0] f7,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eo, input logic eovf, input logic ez,
                       input logic eerr, input logic [3:0] eop, input bit push);
    exp_t e;
    ifc.in_valid = 1'b1;
    ifc.aluOp    = aop;
    ifc.funct7   = f7;
    ifc.funct3   = f3;
    ifc.bus_a    = a;
    ifc.bus_b    = b;
    if (push) begin
      e.name = name; e.out = eo; e.ovf = eovf; e.z = ez; e.err = eerr; e.op = eop;
      sb.push_back(e);
    end
  endtask

  task automatic drive(input string name, input logic [1:0] aop, input logic [6:0] f7,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eo, input logic eovf, input logic ez,
                       input logic eerr, input logic [3:0] eop);
    @(posedge clk);
    #2;
    issue(name, aop, f7, f3, a, b, eo, eovf, ez, eerr, eop, 1'b1);
  endtask

  task automatic idle();
    @(posedge clk);
    #2;
    ifc.in_valid = 1'b0;
    ifc.bus_a    = 32'h1234_5678;
    ifc.bus_b    = 32'h0000_0003;
  endtask

  task automatic check_direct(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Monitor: compare every valid output against the oldest expected entry
  always @(negedge clk) begin
    if (!rst && ifc.out_valid === 1'b1) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got out=%h with no expected entry", ifc.out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (ifc.out !== e.out || ifc.overflow !== e.ovf || ifc.Z !== e.z ||
            ifc.error !== e.err || ifc.opSel !== e.op) begin
          n_fail++;
          $display("FAIL %s: got out=%h ovf=%b Z=%b err=%b opSel=%0d, expected out=%h ovf=%b Z=%b err=%b opSel=%0d",
                   e.name, ifc.out, ifc.overflow, ifc.Z, ifc.error, ifc.opSel,
                   e.out, e.ovf, e.z, e.err, e.op);
        end
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.aluOp    = 2'b00;
    ifc.funct7   = 7'h00;
    ifc.funct3   = 3'b000;
    ifc.bus_a    = '0;
    ifc.bus_b    = '0;
    #1 rst = 1'b1;
    #1;
    check_direct("reset_state", {ifc.out_valid, ifc.error, ifc.Z, ifc.overflow, ifc.opSel, ifc.out[23:0]},
                 {1'b0, 1'b0, 1'b0, 1'b0, 4'd15, 24'd0});
    check_direct("reset_out", ifc.out, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;

    // R-type funct7=0x00, A=1293, B=12
    drive("add",  2'b10, 7'h00, 3'b000, 32'd1293, 32'd12, 32'd1305,    0, 0, 0, 4'd0);
    drive("slt",  2'b10, 7'h00, 3'b010, 32'd1293, 32'd12, 32'd0,       0, 1, 0, 4'd3);
    drive("sltu", 2'b10, 7'h00, 3'b011, 32'd1293, 32'd12, 32'd0,       0, 1, 0, 4'd4);
    drive("xor",  2'b10, 7'h00, 3'b100, 32'd1293, 32'd12, 32'd1281,    0, 0, 0, 4'd5);
    drive("or",   2'b10, 7'h00, 3'b110, 32'd1293, 32'd12, 32'd1293,    0, 0, 0, 4'd8);
    drive("and",  2'b10, 7'h00, 3'b111, 32'd1293, 32'd12, 32'd12,      0, 0, 0, 4'd9);
    drive("sll",  2'b10, 7'h00, 3'b001, 32'd1293, 32'd12, 32'd5296128, 0, 0, 0, 4'd2);
    drive("srl",  2'b10, 7'h00, 3'b101, 32'd1293, 32'd12, 32'd0,       0, 1, 0, 4'd6);
    idle();
    // R-type funct7=0x20
    drive("sub",  2'b10, 7'h20, 3'b000, 32'd1293, 32'd12, 32'd1281,   0, 0, 0, 4'd1);
    drive("sra",  2'b10, 7'h20, 3'b101, 32'h8000_0000, 32'd4, 32'hF800_0000, 0, 0, 0, 4'd7);
    // Overflow and zero flag
    drive("add_ovf",   2'b10, 7'h00, 3'b000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1, 0, 0, 4'd0);
    drive("sub_ovf",   2'b10, 7'h20, 3'b000, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1, 0, 0, 4'd1);
    drive("branch_eq", 2'b01, 7'h00, 3'b000, 32'd5, 32'd5, 32'd0, 0, 1, 0, 4'd1);
    drive("slt_neg",   2'b10, 7'h00, 3'b010, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 0, 0, 4'd3);
    drive("sltu_big",  2'b10, 7'h00, 3'b011, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 1, 0, 4'd4);
    drive("sll_mask",  2'b10, 7'h00, 3'b001, 32'd1, 32'd33, 32'd2, 0, 0, 0, 4'd2);
    drive("ldst",      2'b00, 7'h7F, 3'b011, 32'd100, 32'hFFFF_FFFC, 32'd96, 0, 0, 0, 4'd0);
    drive("addi",      2'b11, 7'h7F, 3'b000, 32'd10, 32'hFFFF_FFFF, 32'd9, 0, 0, 0, 4'd0);
    drive("srai",      2'b11, 7'h20, 3'b101, 32'hFFFF_FF00, 32'h0000_0404, 32'hFFFF_FFF0, 0, 0, 0, 4'd7);
    drive("srli",      2'b11, 7'h00, 3'b101, 32'hFFFF_FF00, 32'd4, 32'h0FFF_FFF0, 0, 0, 0, 4'd6);
    // Illegal encodings
    drive("err_r20_xor", 2'b10, 7'h20, 3'b100, 32'd1293, 32'd12, 32'd0, 0, 0, 1, 4'd15);
    drive("err_slli",    2'b11, 7'h20, 3'b001, 32'd1293, 32'd12, 32'd0, 0, 0, 1, 4'd15);
    drive("err_r7f",     2'b10, 7'h7F, 3'b000, 32'd0, 32'd0, 32'd0, 0, 0, 1, 4'd15);
`ifdef ALU_MUL_EN
    drive("mul", 2'b10, 7'h01, 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 0, 0, 4'd10);
`else
    drive("mul", 2'b10, 7'h01, 3'b000, 32'd7, 32'hFFFF_FFFD, 32'd0, 0, 0, 1, 4'd15);
`endif
    drive("mul_f3", 2'b10, 7'h01, 3'b001, 32'd7, 32'hFFFF_FFFD, 32'd0, 0, 0, 1, 4'd15);
    idle();
    idle();

    // Asynchronous reset while a valid result is being presented
    @(posedge clk);
    #2;
    issue("pre_rst", 2'b10, 7'h00, 3'b000, 32'd40, 32'd2, 32'd42, 0, 0, 0, 4'd0, 1'b0);
    @(posedge clk);
    #1;
    check_direct("pre_rst_out", ifc.out, 32'd42);
    #1 rst = 1'b1;
    ifc.in_valid = 1'b0;
    #1;
    check_direct("rst_async_out", ifc.out, 32'd0);
    check_direct("rst_async_flags", {28'd0, ifc.out_valid, ifc.error, ifc.Z, ifc.overflow},
                 32'd0);
    check_direct("rst_async_opsel", {28'd0, ifc.opSel}, 32'd15);
    @(posedge clk);
    #2 rst = 1'b0;
    issue("post_rst", 2'b10, 7'h00, 3'b111, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 0, 0, 0, 4'd9, 1'b1);
    @(posedge clk);
    #1;
    check_direct("post_rst_valid", {31'd0, ifc.out_valid}, 32'd1);
    #1 ifc.in_valid = 1'b0;
    idle();
    idle();
    idle();

    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
